// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, writable instruction memory and the IF/ID register.
// One-cycle fetch latency. stall holds PC and IF/ID; a redirect overrides stall and loads a bubble.
module if_stage #(
  parameter int unsigned IM_DEPTH = 128,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_target,
  input  logic                        jump,
  input  logic [31:0]                 jump_target,
  input  logic                        im_we,
  input  logic [$clog2(IM_DEPTH)-1:0] im_waddr,
  input  logic [31:0]                 im_wdata,
  output logic [31:0]                 pc,
  output logic [31:0]                 fd_pc,
  output logic [31:0]                 fd_instr,
  output logic                        fd_valid,
  output logic [31:0]                 fetch_count
);

  localparam int AW = $clog2(IM_DEPTH);

  logic [31:0] mem [IM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_next_seq;

  // Read uses the pre-edge contents, so a same-cycle write to the fetched word returns old data.
  assign fetch_word  = mem[pc[AW+1:2]];
  assign pc_next_seq = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (im_we) begin
      mem[im_waddr] <= im_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_RESET;
      fd_pc       <= 32'd0;
      fd_instr    <= NOP_WORD;
      fd_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (jump || branch_taken) begin
      // Redirect: fd_pc and fetch_count are deliberately left untouched by the bubble.
      pc       <= jump ? jump_target : branch_target;
      fd_instr <= NOP_WORD;
      fd_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next_seq;
      if (flush) begin
        fd_instr <= NOP_WORD;
        fd_valid <= 1'b0;
      end else begin
        fd_instr    <= fetch_word;
        fd_pc       <= pc_next_seq;
        fd_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes hand-computed post-edge state, a monitor pops and compares.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] fdpc;
    logic [31:0] instr;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, jump, im_we;
  logic [31:0] branch_target, jump_target, im_wdata;
  logic [6:0]  im_waddr;
  logic [31:0] pc, fd_pc, fd_instr, fetch_count;
  logic        fd_valid;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .pc(pc), .fd_pc(fd_pc), .fd_instr(fd_instr), .fd_valid(fd_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: state is presented every cycle; compare just after the edge that consumed the inputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",          pc,                  e.pc);
        check("fd_pc",       fd_pc,               e.fdpc);
        check("fd_instr",    fd_instr,            e.instr);
        check("fd_valid",    {31'd0, fd_valid},   {31'd0, e.v});
        check("fetch_count", fetch_count,         e.cnt);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    rst = r; stall = s; flush = f;
    branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
  endtask

  task automatic cyc(input logic [31:0] epc, input logic [31:0] efdpc,
                     input logic [31:0] einstr, input logic ev, input logic [31:0] ecnt);
    exp_t e;
    e.pc = epc; e.fdpc = efdpc; e.instr = einstr; e.v = ev; e.cnt = ecnt;
    exp_q.push_back(e);
    @(negedge clk);
    im_we = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h8C01_0003; prog[1] = 32'h0000_0020;
    prog[2] = 32'h8C03_0000; prog[3] = 32'h0000_0020;
    im_we = 1'b0; im_waddr = '0; im_wdata = '0;

    // Preload all words under reset; every cycle must show reset state.
    for (int i = 0; i < 128; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      im_we = 1'b1; im_waddr = 7'(i);
      im_wdata = (i < 4) ? prog[i] : (32'hA000_0000 | 32'(i));
      cyc(32'h0, 32'h0, 32'h20, 0, 0);
    end

    // Sequential fetch of the first four words
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd4,  32'd4,  32'h8C01_0003, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd8,  32'd8,  32'h0000_0020, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd12, 32'd12, 32'h8C03_0000, 1, 3);
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd16, 32'd16, 32'h0000_0020, 1, 4);

    // Back to pc=8, then stall three cycles (flush ignored while stalled), resume with IM[2]
    drive(0, 0, 0, 0, 0, 1, 32'd8); cyc(32'd8, 32'd16, 32'h20, 0, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0); cyc(32'd8, 32'd16, 32'h20, 0, 4);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd12, 32'd12, 32'h8C03_0000, 1, 5);

    // Flush: pc advances, IF/ID bubbles, count holds
    drive(0, 0, 1, 0, 0, 0, 0); cyc(32'd16, 32'd12, 32'h20, 0, 5);
    drive(0, 0, 0, 0, 0, 0, 0); cyc(32'd20, 32'd20, 32'hA000_0004, 1, 6);

    // Write word 5 while fetching it: old data, then refetch sees new data
    drive(0, 0, 0, 0, 0, 0, 0);
    im_we = 1'b1; im_waddr = 7'd5; im_wdata = 32'hDEAD_BEEF;
    cyc(32'd24, 32'd24, 32'hA000_0005, 1, 7);
    drive(0, 0, 0, 0, 0, 1, 32'd20); cyc(32'd20, 32'd24, 32'h20, 0, 7);
    drive(0, 0, 0, 0, 0, 0, 0);      cyc(32'd24, 32'd24, 32'hDEAD_BEEF, 1, 8);

    // Branch overrides stall
    drive(0, 0, 0, 0, 0, 1, 32'd32);       cyc(32'd32, 32'd24, 32'h20, 0, 8);
    drive(0, 1, 0, 1, 32'hAC, 0, 0);       cyc(32'hAC, 32'd24, 32'h20, 0, 8);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'hB0, 32'hB0, 32'hA000_002B, 1, 9);

    // Jump wins over branch
    drive(0, 0, 0, 1, 32'h80, 1, 32'h40);  cyc(32'h40, 32'hB0, 32'h20, 0, 9);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'h44, 32'h44, 32'hA000_0010, 1, 10);

    // Index wraps modulo depth: 0x204 -> IM[1]
    drive(0, 0, 0, 0, 0, 1, 32'h204);      cyc(32'h204, 32'h44, 32'h20, 0, 10);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'h208, 32'h208, 32'h0000_0020, 1, 11);

    // Branch alone
    drive(0, 0, 0, 1, 32'h100, 0, 0);      cyc(32'h100, 32'h208, 32'h20, 0, 11);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'h104, 32'h104, 32'hA000_0040, 1, 12);

    // PC wraps 0xFFFF_FFFC -> 0
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC); cyc(32'hFFFF_FFFC, 32'h104, 32'h20, 0, 12);
    drive(0, 0, 0, 0, 0, 0, 0);             cyc(32'h0, 32'h0, 32'hA000_007F, 1, 13);

    // Reset coincident with stall and jump; memory survives, first fetch one cycle later
    drive(1, 1, 0, 1, 32'h80, 1, 32'h40);  cyc(32'h0, 32'h0, 32'h20, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'd4, 32'd4, 32'h8C01_0003, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);            cyc(32'd8, 32'd8, 32'h0000_0020, 1, 2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
